// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM command-bus arbiter and the engines it
// grants: state encoding, refresh defaults and grant vector indices.
package sdram_arb_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARBIT = 3'd1;
    localparam logic [2:0] S_AREF  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_ARBIT = S_ARBIT,
        ST_AREF  = S_AREF,
        ST_WRITE = S_WRITE,
        ST_READ  = S_READ
    } arb_state_t;

    // 7.8 us refresh interval at 50 MHz
    localparam int REF_PERIOD_DEF = 390;
    localparam int CNT_W_DEF      = 10;

    // Bit positions of each engine in the one-hot grant vector
    localparam int GNT_REF = 0;
    localparam int GNT_WR  = 1;
    localparam int GNT_RD  = 2;
    localparam int GNT_NUM = 3;

    // One-hot grant for a given arbiter state; all-zero outside a burst
    function automatic logic [GNT_NUM-1:0] grant_decode(arb_state_t st);
        logic [GNT_NUM-1:0] g;
        g = '0;
        case (st)
            ST_AREF:  g[GNT_REF] = 1'b1;
            ST_WRITE: g[GNT_WR]  = 1'b1;
            ST_READ:  g[GNT_RD]  = 1'b1;
            default:  g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer. Counts while run is high, raises ref_req on
// every wrap and flags a sticky overrun if a wrap finds the previous request
// still unserved.
module sdram_ref_timer
    import sdram_arb_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic run,
    input  logic ack,
    output logic ref_req,
    output logic ref_overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REF_PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = run && (cnt == CNT_MAX);

    // Interval counter: parked at zero until the arbiter is running
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)
            cnt <= '0;
        else if (!run || wrap)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // Request/overrun flags; a wrap coinciding with ack re-arms the request
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            ref_req     <= 1'b0;
            ref_overrun <= 1'b0;
        end else if (wrap) begin
            ref_req <= 1'b1;
            if (ref_req && !ack)
                ref_overrun <= 1'b1;
        end else if (ack) begin
            ref_req <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus scheduler: waits for init, then grants whole bursts to the
// refresh, write or read engine, refresh first, write/read round-robin.
module sdram_arbit
    import sdram_arb_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       init_end,
    input  logic       wr_trig,
    input  logic       rd_trig,
    input  logic       ref_end,
    input  logic       wr_end,
    input  logic       rd_end,
    output logic       ref_en,
    output logic       wr_en,
    output logic       rd_en,
    output logic       ref_req,
    output logic       ref_overrun,
    output logic [2:0] arb_state
);

    arb_state_t         state;
    arb_state_t         next_state;
    logic               ref_ack;
    logic               last_wr;
    logic [GNT_NUM-1:0] gnt;

    // State register
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state: refresh beats data, write/read alternate when both pending
    always_comb begin
        next_state = state;
        ref_ack    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (init_end)
                    next_state = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (ref_req) begin
                    next_state = ST_AREF;
                    ref_ack    = 1'b1;
                end else if (wr_trig && rd_trig)
                    next_state = last_wr ? ST_READ : ST_WRITE;
                else if (wr_trig)
                    next_state = ST_WRITE;
                else if (rd_trig)
                    next_state = ST_READ;
            end
            ST_AREF: begin
                if (ref_end)
                    next_state = ST_ARBIT;
            end
            ST_WRITE: begin
                if (wr_end)
                    next_state = ST_ARBIT;
            end
            ST_READ: begin
                if (rd_end)
                    next_state = ST_ARBIT;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Round-robin memory: remembers whether the last data burst was a write
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)
            last_wr <= 1'b0;
        else if (state == ST_ARBIT && next_state == ST_WRITE)
            last_wr <= 1'b1;
        else if (state == ST_ARBIT && next_state == ST_READ)
            last_wr <= 1'b0;
    end

    // Grants registered alongside the state so they are glitch-free
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)
            gnt <= '0;
        else
            gnt <= grant_decode(next_state);
    end

    sdram_ref_timer #(
        .REF_PERIOD (REF_PERIOD),
        .CNT_W      (CNT_W)
    ) u_tmr (
        .sclk        (sclk),
        .s_rst_n     (s_rst_n),
        .run         (state != ST_IDLE),
        .ack         (ref_ack),
        .ref_req     (ref_req),
        .ref_overrun (ref_overrun)
    );

    assign ref_en    = gnt[GNT_REF];
    assign wr_en     = gnt[GNT_WR];
    assign rd_en     = gnt[GNT_RD];
    assign arb_state = state;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit with a short refresh period.
module tb_sdram_arbit;

    localparam int P = 16;

    logic       sclk;
    logic       s_rst_n;
    logic       init_end, wr_trig, rd_trig, ref_end, wr_end, rd_end;
    logic       ref_en, wr_en, rd_en, ref_req, ref_overrun;
    logic [2:0] arb_state;

    typedef struct {
        int         cyc;
        string      nm;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    sdram_arbit #(.REF_PERIOD(P), .CNT_W(10)) dut (
        .sclk        (sclk),
        .s_rst_n     (s_rst_n),
        .init_end    (init_end),
        .wr_trig     (wr_trig),
        .rd_trig     (rd_trig),
        .ref_end     (ref_end),
        .wr_end      (wr_end),
        .rd_end      (rd_end),
        .ref_en      (ref_en),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .ref_req     (ref_req),
        .ref_overrun (ref_overrun),
        .arb_state   (arb_state)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic push(input int c, input string nm, input logic [7:0] v);
        exp_t e;
        e.cyc = c;
        e.nm  = nm;
        e.val = v;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] obs(input string nm);
        if (nm == "gnt")     return {5'd0, ref_en, wr_en, rd_en};
        if (nm == "state")   return {5'd0, arb_state};
        if (nm == "ref_req") return {7'd0, ref_req};
        if (nm == "ovr")     return {7'd0, ref_overrun};
        return 8'hxx;
    endfunction

    // Reset, release, pulse init_end; returns at the first ARBIT cycle (n=0)
    task automatic init_seq();
        s_rst_n  = 1'b0;
        init_end = 1'b0; wr_trig = 1'b0; rd_trig = 1'b0;
        ref_end  = 1'b0; wr_end  = 1'b0; rd_end  = 1'b0;
        repeat (2) @(negedge sclk);
        s_rst_n = 1'b1;
        @(negedge sclk);
        init_end = 1'b1;
        @(negedge sclk);
        init_end = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        logic [7:0] a;
        s_rst_n  = 1'b0;
        init_end = 1'b0; wr_trig = 1'b0; rd_trig = 1'b0;
        ref_end  = 1'b0; wr_end  = 1'b0; rd_end  = 1'b0;
        repeat (3) @(negedge sclk);
        s_rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge sclk);
            a = {arb_state, ref_en, wr_en, rd_en, ref_req, ref_overrun};
            n_chk++;
            if (a !== 8'd0 || dut.u_tmr.cnt !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: outputs %0h cnt %0d, want 0 / 0", i, a, dut.u_tmr.cnt);
            end
        end
        init_end = 1'b1;
        @(negedge sclk);
        init_end = 1'b0;
        n_chk++;
        if (arb_state !== 3'd1) begin
            n_fail++;
            $display("FAIL init_to_arbit: state %0d, want 1", arb_state);
        end
        for (int k = 1; k <= P; k++) begin
            @(negedge sclk);
            n_chk++;
            if (ref_req !== (k == P)) begin
                n_fail++;
                $display("FAIL first_ref_req cyc %0d: ref_req %b, want %b", k, ref_req, (k == P));
            end
        end
    endtask

    task automatic test_single_write();
        logic [7:0] a;
        init_seq();
        wr_trig = 1'b1;
        push(1, "gnt", 8'b010); push(1, "state", 8'd3);
        for (int n = 1; n <= 7; n++) begin
            @(negedge sclk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == n) begin
                    a = obs(sb[i].nm);
                    n_chk++;
                    if (a !== sb[i].val) begin
                        n_fail++;
                        $display("FAIL wr_%s cyc %0d: got %0h, want %0h", sb[i].nm, n, a, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
            case (n)
                1: push(2, "gnt", 8'b010);
                2: push(3, "gnt", 8'b010);
                3: begin
                    wr_end = 1'b1;
                    push(4, "gnt", 8'b000); push(4, "state", 8'd1); push(5, "gnt", 8'b010);
                end
                4: wr_end = 1'b0;
                5: begin
                    wr_end = 1'b1; wr_trig = 1'b0;
                    push(6, "gnt", 8'b000);
                end
                6: wr_end = 1'b0;
                default: ;
            endcase
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL wr_pending: %0d left, want 0", sb.size()); end
    endtask

    task automatic test_round_robin();
        logic [2:0] g, prev, e;
        logic [2:0] exp_ord[$];
        int len, seen;
        bit done;
        init_seq();
        exp_ord = '{3'b010, 3'b001, 3'b010, 3'b001};
        wr_trig = 1'b1; rd_trig = 1'b1;
        prev = 3'b000; len = 0; seen = 0; done = 1'b0;
        for (int n = 1; n <= 400 && !done; n++) begin
            @(negedge sclk);
            g = {ref_en, wr_en, rd_en};
            n_chk++;
            if (!(g == 3'b000 || g == 3'b001 || g == 3'b010 || g == 3'b100) ||
                (prev != 3'b000 && g != 3'b000 && g != prev)) begin
                n_fail++;
                $display("FAIL rr_onehot cyc %0d: grants %b after %b, want one-hot with gap", n, g, prev);
            end
            if (g != 3'b000 && g != prev && g != 3'b100 && exp_ord.size() > 0) begin
                e = exp_ord.pop_front();
                seen++;
                n_chk++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL rr_order burst %0d: grants %b, want %b", seen, g, e);
                end
                if (seen == 4) begin wr_trig = 1'b0; rd_trig = 1'b0; end
            end
            len = (g != 3'b000 && g == prev) ? len + 1 : ((g != 3'b000) ? 1 : 0);
            wr_end  = (g == 3'b010 && len == 10);
            rd_end  = (g == 3'b001 && len == 10);
            ref_end = (g == 3'b100 && len == 3);
            if (seen >= 4 && g == 3'b000) done = 1'b1;
            prev = g;
        end
        wr_end = 1'b0; rd_end = 1'b0; ref_end = 1'b0;
        n_chk++;
        if (!done) begin n_fail++; $display("FAIL rr_timeout: bursts %0d, want 4", seen); end
    endtask

    task automatic test_ref_priority();
        logic [7:0] a;
        init_seq();
        for (int n = 1; n <= 22; n++) begin
            @(negedge sclk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == n) begin
                    a = obs(sb[i].nm);
                    n_chk++;
                    if (a !== sb[i].val) begin
                        n_fail++;
                        $display("FAIL refpri_%s cyc %0d: got %0h, want %0h", sb[i].nm, n, a, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
            case (n)
                14: push(15, "ref_req", 8'd0);
                15: begin push(16, "ref_req", 8'd1); push(16, "state", 8'd1); push(16, "gnt", 8'b000); end
                16: begin
                    wr_trig = 1'b1;
                    push(17, "gnt", 8'b100); push(17, "ref_req", 8'd0); push(17, "state", 8'd2);
                end
                18: push(19, "gnt", 8'b100);
                19: begin
                    ref_end = 1'b1;
                    push(20, "gnt", 8'b000); push(20, "state", 8'd1);
                    push(21, "gnt", 8'b010); push(21, "state", 8'd3);
                end
                20: ref_end = 1'b0;
                21: begin wr_end = 1'b1; wr_trig = 1'b0; push(22, "gnt", 8'b000); end
                22: wr_end = 1'b0;
                default: ;
            endcase
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL refpri_pending: %0d left, want 0", sb.size()); end
    endtask

    task automatic test_wrap_ack();
        logic [7:0] a;
        init_seq();
        wr_trig = 1'b1;
        push(1, "gnt", 8'b010);
        for (int n = 1; n <= 36; n++) begin
            @(negedge sclk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == n) begin
                    a = obs(sb[i].nm);
                    n_chk++;
                    if (a !== sb[i].val) begin
                        n_fail++;
                        $display("FAIL wrapack_%s cyc %0d: got %0h, want %0h", sb[i].nm, n, a, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
            case (n)
                14: push(15, "ref_req", 8'd0);
                15: begin push(16, "ref_req", 8'd1); push(16, "gnt", 8'b010); end
                30: begin
                    wr_end = 1'b1; wr_trig = 1'b0;
                    push(31, "state", 8'd1); push(31, "ref_req", 8'd1); push(31, "ovr", 8'd0);
                    push(32, "gnt", 8'b100); push(32, "ref_req", 8'd1); push(32, "ovr", 8'd0);
                end
                31: wr_end = 1'b0;
                32: begin
                    ref_end = 1'b1;
                    push(33, "state", 8'd1); push(33, "ref_req", 8'd1);
                    push(34, "gnt", 8'b100); push(34, "ref_req", 8'd0);
                end
                33: ref_end = 1'b0;
                35: begin ref_end = 1'b1; push(36, "gnt", 8'b000); push(36, "ovr", 8'd0); end
                36: ref_end = 1'b0;
                default: ;
            endcase
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL wrapack_pending: %0d left, want 0", sb.size()); end
    endtask

    task automatic test_overrun();
        logic [7:0] a;
        init_seq();
        wr_trig = 1'b1;
        push(1, "gnt", 8'b010);
        for (int n = 1; n <= 45; n++) begin
            @(negedge sclk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == n) begin
                    a = obs(sb[i].nm);
                    n_chk++;
                    if (a !== sb[i].val) begin
                        n_fail++;
                        $display("FAIL ovr_%s cyc %0d: got %0h, want %0h", sb[i].nm, n, a, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
            case (n)
                30: begin push(31, "ovr", 8'd0); push(31, "ref_req", 8'd1); end
                31: begin push(32, "ovr", 8'd1); push(32, "ref_req", 8'd1); push(32, "gnt", 8'b010); end
                40: begin
                    wr_end = 1'b1; wr_trig = 1'b0;
                    push(41, "gnt", 8'b000); push(41, "ovr", 8'd1);
                    push(42, "gnt", 8'b100); push(42, "ref_req", 8'd0);
                end
                41: wr_end = 1'b0;
                43: begin ref_end = 1'b1; push(44, "gnt", 8'b000); push(44, "ovr", 8'd1); end
                44: ref_end = 1'b0;
                default: ;
            endcase
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL ovr_pending: %0d left, want 0", sb.size()); end
        s_rst_n = 1'b0;
        #1;
        n_chk++;
        if (ref_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_reset: ref_overrun %b, want 0", ref_overrun); end
    endtask

    task automatic test_reset_midburst();
        logic [7:0] a;
        init_seq();
        rd_trig = 1'b1;
        @(negedge sclk);
        n_chk++;
        if ({ref_en, wr_en, rd_en} !== 3'b001) begin
            n_fail++;
            $display("FAIL midrst_grant: grants %b, want 001", {ref_en, wr_en, rd_en});
        end
        repeat (2) @(negedge sclk);
        #2 s_rst_n = 1'b0;
        #1;
        a = {arb_state, ref_en, wr_en, rd_en, ref_req, ref_overrun};
        n_chk++;
        if (a !== 8'd0) begin n_fail++; $display("FAIL midrst_async: outputs %0h, want 0", a); end
        @(negedge sclk);
        s_rst_n = 1'b1; rd_trig = 1'b0;
        rd_end = 1'b1; ref_end = 1'b1; wr_end = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sclk);
            rd_end = 1'b0; ref_end = 1'b0; wr_end = 1'b0;
            if (i == 1) begin rd_end = 1'b1; ref_end = 1'b1; end
            a = {arb_state, ref_en, wr_en, rd_en, ref_req, ref_overrun};
            n_chk++;
            if (a !== 8'd0) begin n_fail++; $display("FAIL midrst_stray cyc %0d: outputs %0h, want 0", i, a); end
        end
        init_end = 1'b1;
        @(negedge sclk);
        init_end = 1'b0;
        @(negedge sclk);
        n_chk++;
        if (arb_state !== 3'd1 || {ref_en, wr_en, rd_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_rearm: state %0d grants %b, want 1 / 000", arb_state, {ref_en, wr_en, rd_en});
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_ref_priority();
        test_wrap_ack();
        test_overrun();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
